reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS-style datapath.
- Generalises the original 32x32, 2-read/1-write file in width, depth and port count.
- Adds a hardwired zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard used by the hazard unit to stall on pending writebacks.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 32, number of registers; power of two, at least 2; AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never written or marked busy.
- BYPASS, 1, when 1, a read of an address written this cycle returns the incoming write data.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- rd_addr_i  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*DATA_W  read data per port; combinational.
- rd_busy_o  out  NUM_RD  busy flag of each addressed register; combinational.
- wr_en_i  in  NUM_WR  write enables.
- wr_addr_i  in  NUM_WR*AW  write addresses.
- wr_data_i  in  NUM_WR*DATA_W  write data.
- busy_set_i  in  1  marks a register as awaiting writeback (issued at decode).
- busy_addr_i  in  AW  register to mark busy.
- busy_flush_i  in  1  clears all busy bits (pipeline flush).

Behaviour:
- Reset: on a rising clk_i edge with rst_i=1, all registers are set to 0 and all busy bits to 0; all writes, busy sets and flushes in that cycle are ignored.
  - With reset asserted, rd_data_o and rd_busy_o therefore read 0 from the next cycle onward.
  - Reset asserted mid-stream discards any pending write in that cycle.
- Write timing: storage updates on the rising edge where wr_en_i[j]=1. Write latency is 1 cycle when BYPASS=0 and 0 cycles as seen through reads when BYPASS=1.
- Write-write conflict: two write ports enabled to the same address in one cycle: the higher port index wins, for both storage and bypass.
- Zero register (ZERO_REG=1): writes to address 0 are dropped. A read of address 0 returns 0 and busy 0 regardless of bypass.
- Read: rd_data_o[k] = storage[rd_addr_i[k]], except when BYPASS=1 and some enabled write port targets the same address; then it returns that port's wr_data_i (highest index wins).
- Scoreboard, next-state for busy[a] each non-reset edge, in priority order:
  1. busy_flush_i=1 -> 0 for all a. A busy_set_i in the same cycle is also dropped.
  2. Otherwise busy_set_i=1 and busy_addr_i=a -> 1. Set wins over a simultaneous writeback to a, because a new producer has been issued.
  3. Otherwise any wr_en_i[j]=1 with wr_addr_i[j]=a -> 0.
  4. Otherwise hold.
- Busy read: rd_busy_o[k] = busy[rd_addr_i[k]]. When BYPASS=1 and a write to that address occurs this cycle, rd_busy_o[k]=0, since the data is being forwarded.
- Writes to a non-busy register are legal and update storage; the busy bit stays 0.
- There is no read-during-reset hazard: outputs are purely combinational from state.
- An out-of-range address cannot occur because DEPTH is a power of two.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_W/DEPTH constants;
  - the AW derivation function;
  - port-slice helper functions, used by the decode and hazard units.
- One natural sub-module: reg_file_scoreboard (busy bit array, set/clear/flush priority, per-port busy lookup).
- Storage, write-port priority and bypass muxing stay in the top module.

Test Plan:
1. Reset: write 0xDEADBEEF to r5 while rst_i=1 -> after the edge r5 reads 0x00000000 and all rd_busy_o read 0.
2. Write/read: write 0x12345678 to r3, then read r3 on both ports next cycle -> 0x12345678 on both. With BYPASS=1, a same-cycle read of r3 while writing 0xCAFEF00D -> 0xCAFEF00D.
3. Zero register: write 0xFFFFFFFF to r0, then busy_set_i on r0 -> r0 reads 0x00000000 and busy 0 in both the same and the next cycle.
4. Dual write conflict (NUM_WR=2): port0 writes r7=0x1, port1 writes r7=0x2 in the same cycle -> r7 reads 0x2 next cycle and on the bypass path.
5. Scoreboard: busy_set_i r9 -> rd_busy 1 next cycle. Then writeback to r9 -> busy 0 next cycle, and 0 during the writeback cycle with BYPASS=1. Then set and writeback to r9 in the same cycle -> busy 1 next cycle.
6. Flush: set busy on r2, r4, r6, then assert busy_flush_i together with busy_set_i r8 -> all busy bits 0 next cycle, including r8; register data unchanged.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file and the
// decode/hazard logic that slices its packed port buses.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits: flush beats set, set beats writeback, else hold.
// Read lookups report not-busy when the value is being forwarded this cycle.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic                 busy_set_i,
    input  logic [AW-1:0]        busy_addr_i,
    input  logic                 busy_flush_i
);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j]) begin
                wb_hit[wr_addr_i[slice_lo(j, AW) +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next = busy_reg;
        for (int a = 0; a < DEPTH; a++) begin
            if (busy_flush_i) begin
                busy_next[a] = 1'b0;
            end else if (busy_set_i && (busy_addr_i == AW'(a))) begin
                busy_next[a] = 1'b1;
            end else if (wb_hit[a]) begin
                busy_next[a] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic          fwd;
        logic          busy;

        assign addr = rd_addr_i[slice_lo(gi, AW) +: AW];

        always_comb begin
            fwd = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if ((BYPASS != 0) && wr_en_i[j] && (wr_addr_i[slice_lo(j, AW) +: AW] == addr)) begin
                    fwd = 1'b1;
                end
            end
            if (((ZERO_REG != 0) && (addr == '0)) || fwd) begin
                busy = 1'b0;
            end else begin
                busy = busy_reg[addr];
            end
        end

        assign rd_busy_o[gi] = busy;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional hardwired zero register,
// same-cycle write-to-read forwarding and a busy scoreboard for the hazard unit.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     busy_set_i,
    input  logic [AW-1:0]            busy_addr_i,
    input  logic                     busy_flush_i
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Ports are visited in ascending order so the highest enabled index
    // issues the last non-blocking assignment and wins a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] &&
                    !((ZERO_REG != 0) && (wr_addr_i[slice_lo(j, AW) +: AW] == '0))) begin
                    mem[wr_addr_i[slice_lo(j, AW) +: AW]] <= wr_data_i[slice_lo(j, DATA_W) +: DATA_W];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr_i[slice_lo(gi, AW) +: AW];

        always_comb begin
            data = mem[addr];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[slice_lo(j, AW) +: AW] == addr)) begin
                        data = wr_data_i[slice_lo(j, DATA_W) +: DATA_W];
                    end
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end
        end

        assign rd_data_o[slice_lo(gi, DATA_W) +: DATA_W] = data;
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_addr_i    (rd_addr_i),
        .rd_busy_o    (rd_busy_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .busy_set_i   (busy_set_i),
        .busy_addr_i  (busy_addr_i),
        .busy_flush_i (busy_flush_i)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (32x32, 2 read / 2 write, zero reg, bypass on):
// directed vector table followed by random traffic against an array model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic [1:0]  wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        busy_set_i;
    logic [4:0]  busy_addr_i;
    logic        busy_flush_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit [31:0] m_mem  [32];
    bit        m_busy [32];

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (32),
        .DEPTH    (32),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_busy_o    (rd_busy_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .busy_set_i   (busy_set_i),
        .busy_addr_i  (busy_addr_i),
        .busy_flush_i (busy_flush_i)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  en;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        set;
        logic [4:0]  sa;
        logic        flush;
        logic        chk;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
    } vec_t;

    function automatic vec_t mk(input string name, input logic rst, input logic [1:0] en,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic set, input logic [4:0] sa, input logic flush,
                                input logic chk, input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic [1:0] eb);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.set = set; v.sa = sa; v.flush = flush;
        v.chk = chk; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
        return v;
    endfunction

    function automatic logic [4:0] wa(input int j);
        return wr_addr_i[j*5 +: 5];
    endfunction

    function automatic logic [31:0] wd(input int j);
        return wr_data_i[j*32 +: 32];
    endfunction

    // Expected read data: zero reg reads 0, else storage overridden by the
    // highest-numbered write to the same address this cycle.
    function automatic logic [31:0] exp_data(input logic [4:0] addr);
        logic [31:0] v;
        if (addr == 5'd0) return 32'd0;
        v = m_mem[addr];
        for (int j = 0; j < 2; j++) begin
            if (wr_en_i[j] && wa(j) == addr) v = wd(j);
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] addr);
        if (addr == 5'd0) return 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (wr_en_i[j] && wa(j) == addr) return 1'b0;
        end
        return m_busy[addr];
    endfunction

    // Applies the edge's effect to the model: writes in port order, then
    // writeback clears, then a set (so set beats writeback), unless flushed.
    task automatic model_step();
        if (rst_i) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[a]  = 32'd0;
                m_busy[a] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en_i[j] && wa(j) != 5'd0) m_mem[wa(j)] = wd(j);
            end
            if (busy_flush_i) begin
                for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (wr_en_i[j]) m_busy[wa(j)] = 1'b0;
                end
                if (busy_set_i && busy_addr_i != 5'd0) m_busy[busy_addr_i] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        rst_i        = v.rst;
        wr_en_i      = v.en;
        wr_addr_i    = {v.wa1, v.wa0};
        wr_data_i    = {v.wd1, v.wd0};
        rd_addr_i    = {v.ra1, v.ra0};
        busy_set_i   = v.set;
        busy_addr_i  = v.sa;
        busy_flush_i = v.flush;
    endtask

    vec_t vecs [$];

    initial begin
        vec_t v;
        v = mk("idle", 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        apply(v);

        //        name         rst en     wa0    wd0            wa1    wd1    ra0    ra1    set   sa     fl    chk   ed0            ed1            eb
        vecs.push_back(mk("reset_wr",   1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("reset_rd",   0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("wr_r3",      0, 2'b01, 5'd3, 32'h12345678, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("rd_r3",      0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 32'h12345678,  32'h12345678,  2'b00));
        vecs.push_back(mk("byp_r3",     0, 2'b01, 5'd3, 32'hCAFEF00D, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 32'hCAFEF00D,  32'hCAFEF00D,  2'b00));
        vecs.push_back(mk("zero_wr",    0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'hCAFEF00D,  2'b00));
        vecs.push_back(mk("zero_set",   0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("zero_next",  0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("dual_wr",    0, 2'b11, 5'd7, 32'd1,        5'd7, 32'd2, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 32'd2,         32'd2,         2'b00));
        vecs.push_back(mk("dual_rd",    0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 32'd2,         32'd2,         2'b00));
        vecs.push_back(mk("set_r9",     0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("busy_r9",    0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b11));
        vecs.push_back(mk("wb_r9",      0, 2'b01, 5'd9, 32'hAAAA0009, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 32'hAAAA0009,  32'hAAAA0009,  2'b00));
        vecs.push_back(mk("wb_r9_rd",   0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 32'hAAAA0009,  32'hAAAA0009,  2'b00));
        vecs.push_back(mk("set_wb_r9",  0, 2'b01, 5'd9, 32'hBBBB0009, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1, 32'hBBBB0009,  32'hBBBB0009,  2'b00));
        vecs.push_back(mk("set_wins",   0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 32'hBBBB0009,  32'hBBBB0009,  2'b11));
        vecs.push_back(mk("set_r2",     0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd3, 5'd7, 1'b1, 5'd2, 1'b0, 1'b1, 32'hCAFEF00D,  32'd2,         2'b00));
        vecs.push_back(mk("set_r4",     0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd2, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1, 32'd0,         32'hCAFEF00D,  2'b01));
        vecs.push_back(mk("set_r6",     0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd4, 5'd2, 1'b1, 5'd6, 1'b0, 1'b1, 32'd0,         32'd0,         2'b11));
        vecs.push_back(mk("flush",      0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd6, 5'd9, 1'b1, 5'd8, 1'b1, 1'b1, 32'd0,         32'hBBBB0009,  2'b11));
        vecs.push_back(mk("flush_a",    0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd2, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("flush_b",    0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd6, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("flush_c",    0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 32'hBBBB0009,  32'hCAFEF00D,  2'b00));
        vecs.push_back(mk("rst_mid",    1, 2'b01, 5'd9, 32'h00000055, 5'd0, 32'd0, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 32'd0,         32'd0,         2'b00));
        vecs.push_back(mk("rst_mid_rd", 0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 32'd0,         32'd0,         2'b00));

        cycle();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("%s.data0", vecs[i].name), rd_data_o[31:0],  vecs[i].ed0);
                check($sformatf("%s.data1", vecs[i].name), rd_data_o[63:32], vecs[i].ed1);
                check($sformatf("%s.busy0", vecs[i].name), {31'd0, rd_busy_o[0]}, {31'd0, vecs[i].eb[0]});
                check($sformatf("%s.busy1", vecs[i].name), {31'd0, rd_busy_o[1]}, {31'd0, vecs[i].eb[1]});
            end
            cycle();
        end

        // Random traffic on a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst_i        = ($urandom_range(0, 39) == 0);
            wr_en_i      = 2'($urandom_range(0, 3));
            wr_addr_i    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data_i    = {$urandom, $urandom};
            rd_addr_i    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            busy_set_i   = ($urandom_range(0, 2) == 0);
            busy_addr_i  = 5'($urandom_range(0, 7));
            busy_flush_i = ($urandom_range(0, 15) == 0);
            #2;
            check($sformatf("rnd%0d.data0", n), rd_data_o[31:0],  exp_data(rd_addr_i[4:0]));
            check($sformatf("rnd%0d.data1", n), rd_data_o[63:32], exp_data(rd_addr_i[9:5]));
            check($sformatf("rnd%0d.busy0", n), {31'd0, rd_busy_o[0]}, {31'd0, exp_busy(rd_addr_i[4:0])});
            check($sformatf("rnd%0d.busy1", n), {31'd0, rd_busy_o[1]}, {31'd0, exp_busy(rd_addr_i[9:5])});
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
